req_ack_protocol_monitor: RTL
=============================

// Module: req_ack_protocol_monitor
// PURPOSE
//  Synthesisable, multi-channel req->ack handshake checker; next generation of the single-channel
//  "req |=> ack, disable iff reset" property check. Each channel checks that ack follows every req
//  within a [MIN_LAT, MAX_LAT] cycle window. Reports pass/fail pulses, fail cause, sticky errors and
//  saturating per-channel counters. Sits beside bus masters in sim and FPGA builds as a live checker.
// PARAMETERS
//  N_CH        4   number of independent req/ack channels
//  MIN_LAT     1   earliest legal ack, in cycles after the req sample edge (>=1)
//  MAX_LAT     1   latest legal ack (>=MIN_LAT, <=255); MIN=MAX=1 is exactly req |=> ack
//  CNT_W       8   width of each saturating pass/fail counter
//  OVERLAP_CHK 1   1: a req sampled while a check is pending is a fail; 0: ignored
//  SPUR_CHK    0   1: an ack sampled while idle is a fail; 0: ignored
// PORTS
//  clk         in   1            rising-edge clock
//  rst         in   1            synchronous, active-low reset (rst==0 resets on next clk edge)
//  dis         in   1            synchronous disable (disable-iff): abort all checks, no reporting
//  clr         in   1            clear sticky errors and all counters
//  req         in   N_CH         per-channel request
//  ack         in   N_CH         per-channel acknowledge
//  pass        out  N_CH         1-cycle pulse: handshake completed legally
//  fail        out  N_CH         1-cycle pulse: violation detected
//  fail_cause  out  2*N_CH       [2c+1:2c] valid with fail[c]: 0 TIMEOUT,1 EARLY,2 OVERLAP,3 SPURIOUS
//  err_sticky  out  N_CH         set by fail[c], held until clr or reset
//  pass_cnt    out  CNT_W*N_CH   per-channel saturating pass count
//  fail_cnt    out  CNT_W*N_CH   per-channel saturating fail count
// BEHAVIOUR
//  - Reset (rst==0 at edge): all channels IDLE, lat=0; every output 0. Dominates dis and clr.
//  - dis==1 at edge: all channels -> IDLE, pass/fail=0, sticky and counters hold. Pending checks
//    are discarded, not failed. clr is still honoured while dis==1.
//  - Per channel, at each edge E (inputs sampled at E; outputs registered, visible the cycle after E):
//    IDLE: req=1 -> WAIT, lat=1. ack=1 & req=0 & SPUR_CHK -> fail SPURIOUS.
//          req=1 & ack=1 in IDLE: req starts a check; the ack is not credited to it and no SPURIOUS.
//    WAIT: ack=1 & lat>=MIN_LAT -> pass. ack=1 & lat<MIN_LAT -> fail EARLY.
//          ack=0 & lat==MAX_LAT -> fail TIMEOUT. Otherwise lat++.
//          On pass/fail: req=1 at the same edge -> stay WAIT, lat=1 (back-to-back check, no overlap).
//          Else -> IDLE. Not resolving & req=1 & OVERLAP_CHK -> fail OVERLAP, check continues.
//  - At most one pass or fail per channel per cycle. Priority: EARLY/TIMEOUT > OVERLAP.
//  - lat: 8-bit, never exceeds MAX_LAT.
//  - Counters saturate at 2**CNT_W-1. clr zeroes them; a pass/fail at the clr edge is lost
//    (clr wins). err_sticky |= fail unless clr.
//  - Channels fully independent; only rst, dis and clr are shared.
// STRUCTURE
//  - req_ack_mon_pkg: typedef enum {IDLE, WAIT} chk_state_t; typedef enum logic [1:0]
//    {TIMEOUT, EARLY, OVERLAP, SPURIOUS} fail_cause_t; LAT_W=8.
//  - Sub-module req_ack_chan_chk: one channel (FSM, lat, pass/fail/cause, sticky, counters).
//    Top is a generate loop of N_CH instances plus bus packing.
//  - Elaboration-time checks: MIN_LAT>=1, MAX_LAT>=MIN_LAT, MAX_LAT<=255.
// TESTING
//  1. Defaults, rst=0 for 5 cycles, req[0] high 1 cycle, ack[0] high the next cycle
//     -> pass[0] pulse once; pass_cnt[0]=1; fail=0.
//  2. Defaults, req[1] pulse, no ack -> fail[1] one cycle after the edge with lat=1; cause=TIMEOUT;
//     err_sticky[1]=1 until clr.
//  3. MIN_LAT=2, MAX_LAT=4: ack at lat 1 -> EARLY. Ack at lat 3 -> pass. No ack -> TIMEOUT at lat 4.
//  4. MAX_LAT=3, req held 2 cycles -> OVERLAP fail at 2nd edge, then pass on ack at lat 2.
//     Same with OVERLAP_CHK=0 -> pass only.
//  5. Pending check with dis=1 for 1 cycle -> no pass/fail; counters unchanged. rst=0 mid-WAIT
//     -> all outputs 0 the next cycle.
//  6. CNT_W=2, 5 consecutive passes on ch3 -> pass_cnt[3]=3 (saturated). clr -> 0.
//     Ack idle with SPUR_CHK=1 -> SPURIOUS.

Source files
------------

// File: rtl/req_ack_mon_pkg.sv
// Shared types and constants for the req->ack protocol monitor.
package req_ack_mon_pkg;

    // Width of the per-channel latency counter; MAX_LAT is bounded by its range.
    localparam int LAT_W = 8;

    // Per-channel checker state.
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } chk_state_t;

    // Reason reported alongside a fail pulse.
    typedef enum logic [1:0] {
        TIMEOUT  = 2'd0,
        EARLY    = 2'd1,
        OVERLAP  = 2'd2,
        SPURIOUS = 2'd3
    } fail_cause_t;

endpackage

// File: rtl/req_ack_chan_chk.sv
// One req->ack channel checker: window FSM, latency count, registered
// pass/fail pulses with cause, sticky error flag and saturating counters.
module req_ack_chan_chk
    import req_ack_mon_pkg::*;
#(
    parameter int MIN_LAT     = 1,
    parameter int MAX_LAT     = 1,
    parameter int CNT_W       = 8,
    parameter int OVERLAP_CHK = 1,
    parameter int SPUR_CHK    = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dis,
    input  logic             clr,
    input  logic             req,
    input  logic             ack,
    output logic             pass,
    output logic             fail,
    output logic [1:0]       fail_cause,
    output logic             err_sticky,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt
);

    localparam logic [LAT_W-1:0] MIN_L = LAT_W'(MIN_LAT);
    localparam logic [LAT_W-1:0] MAX_L = LAT_W'(MAX_LAT);

    chk_state_t        state, state_nxt;
    logic [LAT_W-1:0]  lat, lat_nxt;
    logic              pass_nxt, fail_nxt, resolve;
    fail_cause_t       cause_q, cause_nxt;

    // Next-state, latency and verdict for the edge being sampled.
    always_comb begin
        state_nxt = state;
        lat_nxt   = lat;
        pass_nxt  = 1'b0;
        fail_nxt  = 1'b0;
        cause_nxt = TIMEOUT;
        resolve   = 1'b0;
        case (state)
            IDLE: begin
                // A req starts a check; a coincident ack is not credited to it.
                if (req) begin
                    state_nxt = WAIT;
                    lat_nxt   = LAT_W'(1);
                end else if (ack && (SPUR_CHK != 0)) begin
                    fail_nxt  = 1'b1;
                    cause_nxt = SPURIOUS;
                end
            end
            WAIT: begin
                if (ack) begin
                    resolve = 1'b1;
                    if (lat >= MIN_L) begin
                        pass_nxt = 1'b1;
                    end else begin
                        fail_nxt  = 1'b1;
                        cause_nxt = EARLY;
                    end
                end else if (lat == MAX_L) begin
                    resolve   = 1'b1;
                    fail_nxt  = 1'b1;
                    cause_nxt = TIMEOUT;
                end
                if (resolve) begin
                    // A req on the resolving edge opens the next check back-to-back.
                    if (req) begin
                        state_nxt = WAIT;
                        lat_nxt   = LAT_W'(1);
                    end else begin
                        state_nxt = IDLE;
                        lat_nxt   = '0;
                    end
                end else begin
                    lat_nxt = lat + LAT_W'(1);
                    if (req && (OVERLAP_CHK != 0)) begin
                        fail_nxt  = 1'b1;
                        cause_nxt = OVERLAP;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                lat_nxt   = '0;
            end
        endcase
    end

    // FSM, latency and verdict registers; disable aborts pending checks silently.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            lat     <= '0;
            pass    <= 1'b0;
            fail    <= 1'b0;
            cause_q <= TIMEOUT;
        end else if (dis) begin
            state   <= IDLE;
            lat     <= '0;
            pass    <= 1'b0;
            fail    <= 1'b0;
            cause_q <= TIMEOUT;
        end else begin
            state   <= state_nxt;
            lat     <= lat_nxt;
            pass    <= pass_nxt;
            fail    <= fail_nxt;
            cause_q <= cause_nxt;
        end
    end

    assign fail_cause = cause_q;

    // Sticky error and saturating counters; clr wins over a same-edge verdict.
    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            err_sticky <= 1'b0;
            pass_cnt   <= '0;
            fail_cnt   <= '0;
        end else if (!dis) begin
            if (fail_nxt) err_sticky <= 1'b1;
            if (pass_nxt && (pass_cnt != '1)) pass_cnt <= pass_cnt + CNT_W'(1);
            if (fail_nxt && (fail_cnt != '1)) fail_cnt <= fail_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/req_ack_protocol_monitor.sv
// Multi-channel req->ack handshake monitor: N_CH independent channel checkers
// sharing reset, disable and clear, with outputs packed onto flat buses.
module req_ack_protocol_monitor
    import req_ack_mon_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int MIN_LAT     = 1,
    parameter int MAX_LAT     = 1,
    parameter int CNT_W       = 8,
    parameter int OVERLAP_CHK = 1,
    parameter int SPUR_CHK    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dis,
    input  logic                  clr,
    input  logic [N_CH-1:0]       req,
    input  logic [N_CH-1:0]       ack,
    output logic [N_CH-1:0]       pass,
    output logic [N_CH-1:0]       fail,
    output logic [2*N_CH-1:0]     fail_cause,
    output logic [N_CH-1:0]       err_sticky,
    output logic [CNT_W*N_CH-1:0] pass_cnt,
    output logic [CNT_W*N_CH-1:0] fail_cnt
);

    // Reject latency windows the 8-bit latency counter cannot represent.
    if (MIN_LAT < 1) begin : g_bad_min
        $error("req_ack_protocol_monitor: MIN_LAT must be >= 1");
    end
    if (MAX_LAT < MIN_LAT) begin : g_bad_order
        $error("req_ack_protocol_monitor: MAX_LAT must be >= MIN_LAT");
    end
    if (MAX_LAT > 255) begin : g_bad_max
        $error("req_ack_protocol_monitor: MAX_LAT must be <= 255");
    end

    // One checker per channel; channels share only rst, dis and clr.
    for (genvar c = 0; c < N_CH; c++) begin : g_chan
        req_ack_chan_chk #(
            .MIN_LAT     (MIN_LAT),
            .MAX_LAT     (MAX_LAT),
            .CNT_W       (CNT_W),
            .OVERLAP_CHK (OVERLAP_CHK),
            .SPUR_CHK    (SPUR_CHK)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .dis        (dis),
            .clr        (clr),
            .req        (req[c]),
            .ack        (ack[c]),
            .pass       (pass[c]),
            .fail       (fail[c]),
            .fail_cause (fail_cause[2*c +: 2]),
            .err_sticky (err_sticky[c]),
            .pass_cnt   (pass_cnt[CNT_W*c +: CNT_W]),
            .fail_cnt   (fail_cnt[CNT_W*c +: CNT_W])
        );
    end

endmodule
